// File: rtl/block_regfile_stager.sv
// Staging RAM of {reg1, reg0} pairs with an atomic commit sweep into the register file.
// Optional build macro STAGER_CLEAR_EN: zero every slot after reset before accepting writes.
module block_regfile_stager #(
    parameter int data_width = 16,
    parameter int n_blocks = 256,
    parameter int arm_timeout = 8,
    localparam int AW = $clog2(n_blocks)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AW-1:0]           n_active_blocks,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [AW-1:0]           cfg_addr,
    input  logic                    cfg_select,
    input  logic [data_width-1:0]   cfg_value,
    input  logic                    commit,
    output logic                    busy,
    output logic                    commit_done,
    output logic                    commit_error,
    output logic                    sync,
    output logic [AW-1:0]           sync_addr,
    output logic [2*data_width-1:0] sync_value,
    input  logic                    regfile_syncing
);

    localparam int GUARD = 2 * n_blocks + 4;
    localparam int GW = $clog2(GUARD + 1);
    localparam int ACW = $clog2(arm_timeout + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SWEEP,
        ST_CLEAR
    } state_t;

    state_t state;

    logic [AW-1:0]         n_act;
    logic [ACW-1:0]        arm_cnt;
    logic [GW-1:0]         guard_cnt;
    logic                  cfg_accept;
    logic                  wr_hi;
    logic                  wr_lo;
    logic [AW-1:0]         wr_addr;
    logic [data_width-1:0] wr_data;

    logic [data_width-1:0] ram_hi [n_blocks];
    logic [data_width-1:0] ram_lo [n_blocks];

`ifdef STAGER_CLEAR_EN
    logic [AW-1:0] clr_addr;
`endif

    assign cfg_ready  = (state == ST_IDLE) && !commit;
    assign busy       = (state != ST_IDLE);
    assign cfg_accept = cfg_valid && cfg_ready;

    // Single write port: clear sweep owns it in CLEAR, control writes otherwise.
    always_comb begin
        wr_addr = cfg_addr;
        wr_data = cfg_value;
        wr_hi   = cfg_accept && cfg_select;
        wr_lo   = cfg_accept && !cfg_select;
`ifdef STAGER_CLEAR_EN
        if (state == ST_CLEAR) begin
            wr_addr = clr_addr;
            wr_data = '0;
            wr_hi   = 1'b1;
            wr_lo   = 1'b1;
        end
`endif
    end

    // Half-word RAM writes; separate arrays avoid read-modify-write.
    always_ff @(posedge clk) begin
        if (wr_hi) ram_hi[wr_addr] <= wr_data;
        if (wr_lo) ram_lo[wr_addr] <= wr_data;
    end

    // Registered read of the sweep address, every cycle in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_value <= '0;
        end else begin
            sync_value <= {ram_hi[sync_addr], ram_lo[sync_addr]};
        end
    end

    // Commit sequencer: arm the register file, then sweep until it drops syncing.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef STAGER_CLEAR_EN
            state    <= ST_CLEAR;
            clr_addr <= '0;
`else
            state    <= ST_IDLE;
`endif
            sync         <= 1'b0;
            sync_addr    <= '0;
            commit_done  <= 1'b0;
            commit_error <= 1'b0;
            n_act        <= '0;
            arm_cnt      <= '0;
            guard_cnt    <= '0;
        end else begin
            commit_done  <= 1'b0;
            commit_error <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (commit) begin
                        if (n_active_blocks == '0) begin
                            commit_done <= 1'b1;
                        end else begin
                            n_act     <= n_active_blocks;
                            state     <= ST_ARM;
                            sync      <= 1'b1;
                            sync_addr <= '0;
                            arm_cnt   <= '0;
                        end
                    end
                end
                ST_ARM: begin
                    if (regfile_syncing) begin
                        state     <= ST_SWEEP;
                        sync      <= 1'b0;
                        guard_cnt <= '0;
                    end else if (arm_cnt == ACW'(arm_timeout - 1)) begin
                        state        <= ST_IDLE;
                        sync         <= 1'b0;
                        commit_error <= 1'b1;
                    end else begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (!regfile_syncing) begin
                        state       <= ST_IDLE;
                        sync_addr   <= '0;
                        commit_done <= 1'b1;
                    end else if (guard_cnt == GW'(GUARD)) begin
                        state        <= ST_IDLE;
                        sync_addr    <= '0;
                        commit_error <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                        if (sync_addr == n_act - 1'b1) begin
                            sync_addr <= '0;
                        end else begin
                            sync_addr <= sync_addr + 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
`ifdef STAGER_CLEAR_EN
                    if (clr_addr == AW'(n_blocks - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_regfile_stager.sv
// Directed bench for block_regfile_stager with a sweep scoreboard.
// A small register-file model answers sync requests.
module tb_block_regfile_stager;

    localparam int DW = 16;
    localparam int NB = 16;
    localparam int AT = 8;
    localparam int AW = 4;
`ifdef STAGER_CLEAR_EN
    localparam int   CLR_CYC  = 16;
    localparam logic BUSY_RST = 1'b1;
`else
    localparam int   CLR_CYC  = 0;
    localparam logic BUSY_RST = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [AW-1:0]   n_active_blocks;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [AW-1:0]   cfg_addr;
    logic            cfg_select;
    logic [DW-1:0]   cfg_value;
    logic            commit;
    logic            busy;
    logic            commit_done;
    logic            commit_error;
    logic            sync;
    logic [AW-1:0]   sync_addr;
    logic [2*DW-1:0] sync_value;
    logic            regfile_syncing;

    block_regfile_stager #(
        .data_width(DW),
        .n_blocks(NB),
        .arm_timeout(AT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .n_active_blocks(n_active_blocks),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr),
        .cfg_select(cfg_select),
        .cfg_value(cfg_value),
        .commit(commit),
        .busy(busy),
        .commit_done(commit_done),
        .commit_error(commit_error),
        .sync(sync),
        .sync_addr(sync_addr),
        .sync_value(sync_value),
        .regfile_syncing(regfile_syncing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*DW-1:0] val;
    } sb_t;

    sb_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   m_hi [NB];
    logic [DW-1:0]   m_lo [NB];
    logic [2*DW-1:0] rf_mem [NB];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-file model: raise syncing on sync, hold it rf_len sweep cycles.
    logic rf_en;
    int   rf_len;
    int   rf_cnt;
    always @(posedge clk) begin
        if (reset) begin
            regfile_syncing <= 1'b0;
            rf_cnt          <= 0;
        end else if (sync && rf_en) begin
            regfile_syncing <= 1'b1;
            rf_cnt          <= 0;
        end else if (regfile_syncing) begin
            if (rf_cnt == rf_len - 1) regfile_syncing <= 1'b0;
            rf_cnt <= rf_cnt + 1;
        end
    end

    // Monitor: pulse counters, scoreboard pops, register-file capture.
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            sync_hi_cnt = 0;
    bit            mon_en;
    bit            in_sw = 1'b0;
    logic [AW-1:0] prev_addr;
    always @(negedge clk) begin
        if (commit_done) done_cnt++;
        if (commit_error) err_cnt++;
        if (sync) sync_hi_cnt++;
        if (mon_en && busy && !sync) begin
            check("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                check("sweep_addr", sync_addr, e.addr);
                check("sweep_value", sync_value, e.val);
            end
            if (in_sw) rf_mem[prev_addr] = sync_value;
            prev_addr = sync_addr;
            in_sw = 1'b1;
        end else begin
            in_sw = 1'b0;
        end
    end

    task automatic cfg_write(input int a, input bit sel, input logic [DW-1:0] v);
        @(posedge clk); #1;
        cfg_valid  = 1'b1;
        cfg_addr   = AW'(a);
        cfg_select = sel;
        cfg_value  = v;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (sel) m_hi[a] = v;
        else m_lo[a] = v;
    endtask

    task automatic push_sweep(input int n, input int len);
        for (int i = 0; i <= len; i++) begin
            sb_t e;
            int  k;
            k = (i == 0) ? 0 : (i - 1) % n;
            e.addr = AW'(i % n);
            e.val  = {m_hi[k], m_lo[k]};
            sb.push_back(e);
        end
    endtask

    task automatic start_commit(input int n);
        @(posedge clk); #1;
        n_active_blocks = AW'(n);
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({tag, "_end_timeout"}, 64'(k < 300), 1);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        int lo;
        int k;
        reset = 1'b1;
        n_active_blocks = '0;
        cfg_valid = 1'b0;
        cfg_addr = '0;
        cfg_select = 1'b0;
        cfg_value = '0;
        commit = 1'b0;
        rf_en = 1'b1;
        rf_len = 6;
        mon_en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            m_hi[i] = '0;
            m_lo[i] = '0;
            rf_mem[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("rst_sync", sync, 0);
        check("rst_addr", sync_addr, 0);
        check("rst_value", sync_value, 0);
        check("rst_busy", busy, BUSY_RST);
        check("rst_done", commit_done, 0);
        check("rst_err", commit_error, 0);
        check("rst_ready", cfg_ready, !BUSY_RST);
        @(posedge clk); #1;
        reset = 1'b0;

        lo = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cfg_ready) break;
            lo++;
        end
        check("clear_cycles", lo, CLR_CYC);

`ifdef STAGER_CLEAR_EN
        rf_len = 16;
        d0 = done_cnt;
        push_sweep(15, 16);
        start_commit(15);
        wait_end("clr");
        check("clr_done", done_cnt - d0, 1);
        check("clr_sb_empty", sb.size(), 0);
`endif

        cfg_write(0, 1'b0, 16'h0A00);
        cfg_write(0, 1'b1, 16'h0B00);
        cfg_write(1, 1'b0, 16'h0A11);
        cfg_write(1, 1'b1, 16'h0B11);
        cfg_write(2, 1'b0, 16'h0A22);
        cfg_write(2, 1'b1, 16'h0B22);
        cfg_write(3, 1'b0, 16'h1234);
        cfg_write(3, 1'b1, 16'hABCD);

        rf_len = 6;
        d0 = done_cnt;
        e0 = err_cnt;
        sync_hi_cnt = 0;
        push_sweep(4, 6);
        @(posedge clk); #1;
        n_active_blocks = 4'd4;
        commit = 1'b1;
        cfg_valid = 1'b1;
        cfg_addr = 4'd2;
        cfg_select = 1'b0;
        cfg_value = 16'hBEEF;
        #1;
        check("ready_with_commit", cfg_ready, 0);
        @(posedge clk); #1;
        commit = 1'b0;
        cfg_valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy && !sync) break;
        end
        check("t1_reach_sweep", 64'(k < 20), 1);
        cfg_valid = 1'b1;
        cfg_addr = 4'd1;
        cfg_select = 1'b1;
        cfg_value = 16'hDEAD;
        #1;
        check("ready_in_sweep", cfg_ready, 0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        wait_end("t1");
        check("t1_done", done_cnt - d0, 1);
        check("t1_err", err_cnt - e0, 0);
        check("t1_sync_seen", 64'(sync_hi_cnt >= 1), 1);
        check("t1_rf_slot3", rf_mem[3], 32'hABCD1234);
        check("t1_rf_slot1", rf_mem[1], 32'h0B110A11);
        check("t1_sb_empty", sb.size(), 0);
        check("t1_ready_back", cfg_ready, 1);

        rf_len = 9;
        d0 = done_cnt;
        push_sweep(4, 9);
        start_commit(4);
        wait_end("rb");
        check("rb_done", done_cnt - d0, 1);
        check("rb_sb_empty", sb.size(), 0);
        check("rb_rf_slot2", rf_mem[2], 32'h0B220A22);

        rf_len = 3;
        d0 = done_cnt;
        push_sweep(1, 3);
        start_commit(1);
        wait_end("n1");
        check("n1_done", done_cnt - d0, 1);
        check("n1_sb_empty", sb.size(), 0);

        start_commit(0);
        @(negedge clk);
        check("n0_done", commit_done, 1);
        check("n0_sync", sync, 0);
        check("n0_busy", busy, 0);
        @(negedge clk);
        check("n0_done_fall", commit_done, 0);

        rf_en = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        sync_hi_cnt = 0;
        start_commit(4);
        wait_end("to");
        check("to_sync_cycles", sync_hi_cnt, AT);
        check("to_err", err_cnt - e0, 1);
        check("to_no_done", done_cnt - d0, 0);
        check("to_busy", busy, 0);
        check("to_ready", cfg_ready, 1);
        rf_en = 1'b1;

        rf_len = 10;
        push_sweep(4, 10);
        start_commit(4);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy && !sync && sync_addr == 4'd2) break;
        end
        check("rs_reach_addr2", 64'(k < 40), 1);
        mon_en = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("rs_sync", sync, 0);
        check("rs_addr", sync_addr, 0);
        check("rs_busy", busy, BUSY_RST);
        check("rs_done", commit_done, 0);
        check("rs_err", commit_error, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rs_no_done", done_cnt - d0, 0);
        check("rs_no_err", err_cnt - e0, 0);
        sb.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
